// File: rtl/ft600_slave_model.sv
// ft600_slave_model: cycle-level FT600 chip-side model of the 245 sync-FIFO bus
// Ports:
//   usb_clk, rst                          clock, synchronous active-high reset
//   h_it*  (valid/ready/data/be)          host->FPGA stream into the RX buffer
//   h_ot*  (valid/ready/data/be)          FPGA->host stream out of the TX buffer (FWFT)
//   usb_rxf, usb_txe                      active-low RX-available / TX-space flags
//   usb_oe, usb_rd, usb_wr                active-low master strobes
//   usb_data_i/o/t, usb_be_i/o            split tristate data and byte-enable bus
//   err                                   sticky protocol errors {contention, wr-dropped, rd-empty}
module ft600_slave_model #(
    parameter int RX_ASIZE    = 9,
    parameter int TX_ASIZE    = 9,
    parameter int BURST_WORDS = 256,
    parameter int GAP_CYCLES  = 4
) (
    input  logic        usb_clk,
    input  logic        rst,
    input  logic        h_itvalid,
    output logic        h_itready,
    input  logic [15:0] h_itdata,
    input  logic [1:0]  h_itbe,
    output logic        h_otvalid,
    input  logic        h_otready,
    output logic [15:0] h_otdata,
    output logic [1:0]  h_otbe,
    output logic        usb_rxf,
    output logic        usb_txe,
    input  logic        usb_oe,
    input  logic        usb_rd,
    input  logic        usb_wr,
    input  logic [15:0] usb_data_i,
    output logic [15:0] usb_data_o,
    output logic        usb_data_t,
    input  logic [1:0]  usb_be_i,
    output logic [1:0]  usb_be_o,
    output logic [2:0]  err
);
    localparam int BW = $clog2(BURST_WORDS + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_WORDS - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {R_IDLE, R_BURST, R_GAP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_BURST, T_GAP} tx_state_t;

    logic [17:0]         rx_mem [2**RX_ASIZE];
    logic [RX_ASIZE-1:0] rx_wp_q, rx_rp_q;
    logic [RX_ASIZE:0]   rx_cnt_q, rx_cnt_d;
    logic                rx_push, rx_pop;
    logic [17:0]         tx_mem [2**TX_ASIZE];
    logic [TX_ASIZE-1:0] tx_wp_q, tx_rp_q;
    logic [TX_ASIZE:0]   tx_cnt_q, tx_cnt_d;
    logic                tx_push, tx_pop;
    rx_state_t           rs_q;
    tx_state_t           ts_q;
    logic [BW-1:0]       rcnt_q, tcnt_q;
    logic [GW-1:0]       rgap_q, tgap_q;
    logic                rxf_q, txe_q;
    logic [2:0]          err_q;

    // occupancy reaches 2**ASIZE only when full, so the MSB is the full flag
    assign h_itready  = ~rx_cnt_q[RX_ASIZE];
    assign rx_push    = h_itvalid & h_itready;
    assign rx_pop     = ~usb_oe & ~usb_rd & ~rxf_q & (rx_cnt_q != '0);
    assign rx_cnt_d   = rx_cnt_q + (RX_ASIZE+1)'(rx_push) - (RX_ASIZE+1)'(rx_pop);
    assign h_otvalid  = tx_cnt_q != '0;
    assign tx_pop     = h_otvalid & h_otready;
    assign tx_push    = ~usb_wr & ~txe_q & usb_oe & ~tx_cnt_q[TX_ASIZE];
    assign tx_cnt_d   = tx_cnt_q + (TX_ASIZE+1)'(tx_push) - (TX_ASIZE+1)'(tx_pop);
    assign {usb_be_o, usb_data_o} = rx_mem[rx_rp_q];
    assign {h_otbe, h_otdata}     = tx_mem[tx_rp_q];
    assign usb_data_t = ~usb_oe;
    assign usb_rxf    = rxf_q;
    assign usb_txe    = txe_q;
    assign err        = err_q;

    always_ff @(posedge usb_clk) begin
        if (rx_push) rx_mem[rx_wp_q] <= {h_itbe, h_itdata};
        if (tx_push) tx_mem[tx_wp_q] <= {usb_be_i, usb_data_i};
    end

    always_ff @(posedge usb_clk) begin
        if (rst) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            err_q    <= '0;
        end else begin
            rx_wp_q  <= rx_wp_q + RX_ASIZE'(rx_push);
            rx_rp_q  <= rx_rp_q + RX_ASIZE'(rx_pop);
            rx_cnt_q <= rx_cnt_d;
            tx_wp_q  <= tx_wp_q + TX_ASIZE'(tx_push);
            tx_rp_q  <= tx_rp_q + TX_ASIZE'(tx_pop);
            tx_cnt_q <= tx_cnt_d;
            err_q    <= err_q | {~usb_wr & ~usb_oe, ~usb_wr & txe_q, ~usb_rd & rxf_q};
        end
    end

    // the last gap cycle re-arms directly so the flag stays high exactly GAP_CYCLES
    always_ff @(posedge usb_clk) begin
        if (rst) begin
            rs_q   <= R_IDLE;
            rxf_q  <= 1'b1;
            rcnt_q <= '0;
            rgap_q <= '0;
        end else begin
            case (rs_q)
                R_IDLE: if (rx_cnt_q != '0) begin
                    rs_q   <= R_BURST;
                    rxf_q  <= 1'b0;
                    rcnt_q <= '0;
                end
                R_BURST: if (rx_pop) begin
                    rcnt_q <= rcnt_q + 1'b1;
                    if (rx_cnt_d == '0 || rcnt_q == BURST_LAST) begin
                        rs_q   <= R_GAP;
                        rxf_q  <= 1'b1;
                        rgap_q <= '0;
                    end
                end
                default: if (rgap_q == GAP_LAST) begin
                    rs_q   <= (rx_cnt_q != '0) ? R_BURST : R_IDLE;
                    rxf_q  <= rx_cnt_q == '0;
                    rcnt_q <= '0;
                end else begin
                    rgap_q <= rgap_q + 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge usb_clk) begin
        if (rst) begin
            ts_q   <= T_IDLE;
            txe_q  <= 1'b1;
            tcnt_q <= '0;
            tgap_q <= '0;
        end else begin
            case (ts_q)
                T_IDLE: if (!tx_cnt_q[TX_ASIZE]) begin
                    ts_q   <= T_BURST;
                    txe_q  <= 1'b0;
                    tcnt_q <= '0;
                end
                T_BURST: if (tx_push) begin
                    tcnt_q <= tcnt_q + 1'b1;
                    if (tx_cnt_d[TX_ASIZE] || tcnt_q == BURST_LAST) begin
                        ts_q   <= T_GAP;
                        txe_q  <= 1'b1;
                        tgap_q <= '0;
                    end
                end
                default: if (tgap_q == GAP_LAST) begin
                    ts_q   <= tx_cnt_q[TX_ASIZE] ? T_IDLE : T_BURST;
                    txe_q  <= tx_cnt_q[TX_ASIZE];
                    tcnt_q <= '0;
                end else begin
                    tgap_q <= tgap_q + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ft600_slave_model.sv
// tb_ft600_slave_model: directed self-checking bench for the FT600 slave model
module tb_ft600_slave_model;
    logic usb_clk = 0, rst = 1;
    logic h_itvalid = 0, h_otready = 0, oe = 1, rd = 1, wr = 1, wr2 = 1, d2_otready = 0;
    logic [15:0] h_itdata = 0, di = 0;
    logic [1:0] h_itbe = 0, bei = 0;
    logic h_itready, h_otvalid, usb_rxf, usb_txe, dt;
    logic [15:0] h_otdata, usb_data_o;
    logic [1:0] h_otbe, usb_be_o;
    logic [2:0] err;
    logic d2_itready, d2_otvalid, d2_rxf, d2_txe, d2_t;
    logic [15:0] d2_otdata, d2_do;
    logic [1:0] d2_otbe, d2_beo;
    logic [2:0] d2_err;
    int vectors = 0, miscompares = 0, bad;
    int bursts[$], gaps[$];

    always #5 usb_clk = ~usb_clk;

    ft600_slave_model dut (
        .usb_clk(usb_clk), .rst(rst), .h_itvalid(h_itvalid), .h_itready(h_itready),
        .h_itdata(h_itdata), .h_itbe(h_itbe), .h_otvalid(h_otvalid), .h_otready(h_otready),
        .h_otdata(h_otdata), .h_otbe(h_otbe), .usb_rxf(usb_rxf), .usb_txe(usb_txe),
        .usb_oe(oe), .usb_rd(rd), .usb_wr(wr), .usb_data_i(di), .usb_data_o(usb_data_o),
        .usb_data_t(dt), .usb_be_i(bei), .usb_be_o(usb_be_o), .err(err)
    );

    ft600_slave_model #(.TX_ASIZE(2)) dut2 (
        .usb_clk(usb_clk), .rst(rst), .h_itvalid(1'b0), .h_itready(d2_itready),
        .h_itdata(16'h0), .h_itbe(2'b00), .h_otvalid(d2_otvalid), .h_otready(d2_otready),
        .h_otdata(d2_otdata), .h_otbe(d2_otbe), .usb_rxf(d2_rxf), .usb_txe(d2_txe),
        .usb_oe(1'b1), .usb_rd(1'b1), .usb_wr(wr2), .usb_data_i(di), .usb_data_o(d2_do),
        .usb_data_t(d2_t), .usb_be_i(bei), .usb_be_o(d2_beo), .err(d2_err)
    );

    task automatic tick;
        @(posedge usb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // host pushes 1..n_push while a master pops n_read words, reading only while rxf is low
    task automatic stream(input int n_push, input int n_read);
        int pushed = 0, popped = 0, blen = 0, gcnt = 0, t = 0;
        bursts.delete();
        gaps.delete();
        bad = 0;
        while ((pushed < n_push || popped < n_read) && t < 5000) begin
            h_itvalid = pushed < n_push;
            h_itdata = 16'(pushed + 1);
            h_itbe = 2'b11;
            if (h_itvalid && h_itready) pushed++;
            if (!usb_rxf && popped < n_read) begin
                if (gcnt > 0) gaps.push_back(gcnt);
                gcnt = 0;
                if (usb_data_o !== 16'(popped + 1) || usb_be_o !== 2'b11 || dt !== 1'b1) bad++;
                rd = 0;
                popped++;
                blen++;
            end else begin
                rd = 1;
                if (blen > 0) bursts.push_back(blen);
                blen = 0;
                if (bursts.size() > 0 && usb_rxf) gcnt++;
            end
            tick;
            t++;
        end
        h_itvalid = 0;
        rd = 1;
        if (blen > 0) bursts.push_back(blen);
        chk("stream_done", t < 5000, 1);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_rxf", usb_rxf, 1);
        chk("rst_txe", usb_txe, 1);
        chk("rst_err", err, 0);
        chk("rst_itready", h_itready, 1);
        chk("rst_otvalid", h_otvalid, 0);
        chk("rst_d2", {d2_rxf, d2_txe, d2_err, d2_otvalid}, 6'b110000);
        rst = 0;
        chk("dt_idle", dt, 0);
        oe = 0;
        #1 chk("dt_oe", dt, 1);
        stream(3, 3);
        chk("s3_rxf_after", usb_rxf, 1);
        chk("s3_data", bad, 0);
        chk("s3_nburst", bursts.size(), 1);
        chk("s3_burst0", bursts[0], 3);
        stream(600, 600);
        chk("s600_data", bad, 0);
        chk("s600_nburst", bursts.size(), 3);
        chk("s600_b0", bursts[0], 256);
        chk("s600_b1", bursts[1], 256);
        chk("s600_b2", bursts[2], 88);
        chk("s600_ngap", gaps.size(), 2);
        chk("s600_g0", gaps[0], 4);
        chk("s600_g1", gaps[1], 4);
        chk("s600_err", err, 0);
        oe = 1;
        chk("rd_empty_pre", usb_rxf, 1);
        rd = 0;
        tick;
        rd = 1;
        chk("err_rd_empty", err, 3'b001);
        rst = 1;
        tick;
        rst = 0;
        chk("err_cleared", err, 0);
        tick;
        chk("tx_txe_low", usb_txe, 0);
        wr = 0; di = 16'hA5A5; bei = 2'b01;
        tick;
        wr = 1;
        chk("tx_word", {h_otvalid, h_otbe, h_otdata}, {1'b1, 2'b01, 16'hA5A5});
        chk("tx_err", err, 0);
        h_otready = 1;
        tick;
        h_otready = 0;
        chk("tx_drained", h_otvalid, 0);
        oe = 0; wr = 0;
        #1 chk("cont_dt", dt, 1);
        tick;
        oe = 1; wr = 1;
        chk("cont_err", err, 3'b100);
        chk("cont_nopush", h_otvalid, 0);
        rst = 1;
        tick;
        rst = 0;
        chk("cont_rst_err", err, 0);
        tick;
        chk("d2_txe_low", d2_txe, 0);
        for (int i = 0; i < 6; i++) begin
            wr2 = 0; di = 16'h100 + 16'(i); bei = 2'b11;
            tick;
            if (i == 2) chk("d2_txe_after3", d2_txe, 0);
            if (i == 3) chk("d2_txe_after4", d2_txe, 1);
        end
        wr2 = 1;
        chk("d2_err_drop", d2_err, 3'b010);
        d2_otready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("d2_pop", {d2_otvalid, d2_otbe, d2_otdata}, {1'b1, 2'b11, 16'h100 + 16'(i)});
            tick;
        end
        d2_otready = 0;
        chk("d2_holds4", d2_otvalid, 0);
        wr = 0; di = 16'h1234;
        tick;
        wr = 1;
        chk("mid_tx_valid", h_otvalid, 1);
        for (int i = 0; i < 10; i++) begin
            h_itvalid = 1; h_itdata = 16'h50 + 16'(i); h_itbe = 2'b11;
            tick;
        end
        h_itvalid = 0;
        chk("mid_rxf_low", usb_rxf, 0);
        oe = 0; rd = 0;
        tick;
        tick;
        tick;
        chk("mid_burst", {usb_rxf, usb_data_o}, {1'b0, 16'h53});
        rst = 1; oe = 1; rd = 1;
        tick;
        rst = 0;
        chk("mid_rst", {usb_rxf, h_otvalid, h_itready, err}, {3'b101, 3'b000});
        tick;
        tick;
        chk("mid_lost", usb_rxf, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
